pc_fetch_ctrl: RTL and testbench

// Parametrised program-counter and fetch-request controller for the RV32I core. Holds the PC and

---
 rtl/pc_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: RV32I program counter, fetch request handshake, redirect resolution and return-address stack
module pc_fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            halt,
  input  logic            fetch_ready,
  input  logic            jal_en,
  input  logic            br_taken,
  input  logic            jalr_en,
  input  logic            trap_en,
  input  logic [XLEN-1:0] imm_val,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_val,
  output logic            fetch_valid,
  output logic [XLEN-1:0] link_addr,
  output logic            kill_fetch,
  output logic            redir_pend,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_pc, r_ptgt, r_mis_addr;
  logic            r_pend, r_kill, r_mis, r_clr_d;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;

  logic [XLEN-1:0] w_tgt;
  logic            w_fv, w_acc, w_stall, w_any, w_mis, w_ok;
  logic            w_push_only, w_pop_only;
  logic [PW-1:0]   w_wptr;

  always_comb begin
    w_fv    = !halt && !r_clr_d;
    w_acc   = w_fv && fetch_ready;
    w_stall = w_fv && !fetch_ready;
    w_tgt   = trap_en ? trap_vec :
              jalr_en ? ((rs1_val + imm_val) & ~XLEN'(1)) : r_pc + imm_val;
    w_any   = trap_en || jalr_en || jal_en || br_taken;
    w_mis   = !trap_en && w_any && w_tgt[1];
    w_ok    = w_any && !w_mis;
  end

  always_ff @(posedge clk) begin
    r_clr_d <= clr;
    if (clr) begin
      r_pc       <= RESET_VEC;
      r_ptgt     <= '0;
      r_pend     <= 1'b0;
      r_kill     <= 1'b0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis <= w_mis;
      if (w_mis) r_mis_addr <= w_tgt;
      if (trap_en) begin
        r_pc   <= trap_vec;
        r_pend <= 1'b0;
        r_kill <= w_fv;
      end else if (w_stall) begin
        r_kill <= 1'b0;
        if (w_ok) begin
          r_pend <= 1'b1;
          r_ptgt <= w_tgt;
        end
      end else begin
        // a fresh redirect supersedes an older pending one
        r_kill <= w_acc && (w_ok || r_pend);
        r_pend <= 1'b0;
        r_pc   <= w_ok ? w_tgt : r_pend ? r_ptgt : w_acc ? r_pc + XLEN'(4) : r_pc;
      end
    end
  end

  // push+pop on an empty stack behaves as a plain push
  always_comb begin
    w_push_only = ras_push && (!ras_pop || r_cnt == '0);
    w_pop_only  = ras_pop && !ras_push && r_cnt != '0;
    w_wptr      = w_push_only ? r_ptr + PW'(1) : r_ptr;
  end

  always_ff @(posedge clk) begin
    if (ras_push) r_ras[w_wptr] <= link_addr;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_push_only) begin
      r_ptr <= r_ptr + PW'(1);
      r_cnt <= (r_cnt == CW'(RAS_DEPTH)) ? r_cnt : r_cnt + CW'(1);
    end else if (w_pop_only) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign pc_val        = r_pc;
  assign fetch_valid   = w_fv;
  assign link_addr     = r_pc + XLEN'(4);
  assign kill_fetch    = r_kill;
  assign redir_pend    = r_pend;
  assign misalign      = r_mis;
  assign misalign_addr = r_mis_addr;
  assign ras_empty     = r_cnt == '0;
  assign ras_top       = ras_empty ? '0 : r_ras[r_ptr];
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scoreboard bench for pc_fetch_ctrl redirects, stalls, traps, halt, RAS and PC wrap
module tb_pc_fetch_ctrl;
  logic clk = 0;
  logic clr, clr2, halt, fetch_ready, jal_en, br_taken, jalr_en, trap_en, ras_push, ras_pop;
  logic [31:0] imm_val, rs1_val, trap_vec;
  logic [31:0] pc_val, link_addr, misalign_addr, ras_top;
  logic fetch_valid, kill_fetch, redir_pend, misalign, ras_empty;
  logic [31:0] pc2, link2, maddr2, rtop2;
  logic fv2, kill2, pend2, mis2, remp2;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ras_q[$];
  logic [31:0] e, t;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .clr(clr), .halt(halt), .fetch_ready(fetch_ready), .jal_en(jal_en),
    .br_taken(br_taken), .jalr_en(jalr_en), .trap_en(trap_en), .imm_val(imm_val),
    .rs1_val(rs1_val), .trap_vec(trap_vec), .ras_push(ras_push), .ras_pop(ras_pop),
    .pc_val(pc_val), .fetch_valid(fetch_valid), .link_addr(link_addr), .kill_fetch(kill_fetch),
    .redir_pend(redir_pend), .misalign(misalign), .misalign_addr(misalign_addr),
    .ras_top(ras_top), .ras_empty(ras_empty)
  );

  pc_fetch_ctrl #(.RESET_VEC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .clr(clr2), .halt(halt), .fetch_ready(fetch_ready), .jal_en(jal_en),
    .br_taken(br_taken), .jalr_en(jalr_en), .trap_en(trap_en), .imm_val(imm_val),
    .rs1_val(rs1_val), .trap_vec(trap_vec), .ras_push(ras_push), .ras_pop(ras_pop),
    .pc_val(pc2), .fetch_valid(fv2), .link_addr(link2), .kill_fetch(kill2),
    .redir_pend(pend2), .misalign(mis2), .misalign_addr(maddr2),
    .ras_top(rtop2), .ras_empty(remp2)
  );

  task step;
    @(posedge clk); #1;
  endtask

  task idle;
    halt = 0; jal_en = 0; br_taken = 0; jalr_en = 0; trap_en = 0;
    ras_push = 0; ras_pop = 0; imm_val = 0; rs1_val = 0; trap_vec = 0;
  endtask

  task test_reset;
    idle; clr = 1; fetch_ready = 1; exp_q.push_back(32'h0);
    step; e = exp_q.pop_front(); checks += 7;
    if (pc_val !== e) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_val, e); end
    if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
    if (redir_pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", redir_pend); end
    if (kill_fetch !== 1'b0) begin failures++; $display("FAIL reset_kill got=%b exp=0", kill_fetch); end
    if (misalign !== 1'b0 || misalign_addr !== 32'h0) begin failures++; $display("FAIL reset_mis got=%b/%h exp=0/0", misalign, misalign_addr); end
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL reset_ras_empty got=%b exp=1", ras_empty); end
    if (ras_top !== 32'h0) begin failures++; $display("FAIL reset_ras_top got=%h exp=0", ras_top); end
    clr = 0; exp_q.push_back(32'h0);
    step; e = exp_q.pop_front(); checks += 2;
    if (pc_val !== e) begin failures++; $display("FAIL release_pc got=%h exp=%h", pc_val, e); end
    if (fetch_valid !== 1'b1) begin failures++; $display("FAIL release_fv got=%b exp=1", fetch_valid); end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(32'(4 * i));
      step; e = exp_q.pop_front(); checks++;
      if (pc_val !== e) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc_val, e); end
    end
  endtask

  task test_redirect;
    for (int i = 5; i <= 8; i++) begin
      exp_q.push_back(32'(4 * i));
      step; e = exp_q.pop_front(); checks++;
      if (pc_val !== e) begin failures++; $display("FAIL pre_redir_pc got=%h exp=%h", pc_val, e); end
    end
    fetch_ready = 0; jal_en = 1; imm_val = 32'h100; exp_q.push_back(32'h20);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL stall_pc got=%h exp=%h", pc_val, e); end
    if (redir_pend !== 1'b1) begin failures++; $display("FAIL stall_pend got=%b exp=1", redir_pend); end
    if (kill_fetch !== 1'b0) begin failures++; $display("FAIL stall_kill got=%b exp=0", kill_fetch); end
    jal_en = 0; imm_val = 0; exp_q.push_back(32'h20);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e || redir_pend !== 1'b1) begin failures++; $display("FAIL hold_pc got=%h/%b exp=%h/1", pc_val, redir_pend, e); end
    fetch_ready = 1; exp_q.push_back(32'h120);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL apply_pc got=%h exp=%h", pc_val, e); end
    if (kill_fetch !== 1'b1) begin failures++; $display("FAIL apply_kill got=%b exp=1", kill_fetch); end
    if (redir_pend !== 1'b0) begin failures++; $display("FAIL apply_pend got=%b exp=0", redir_pend); end
    exp_q.push_back(32'h124);
    step; e = exp_q.pop_front(); checks += 2;
    if (pc_val !== e) begin failures++; $display("FAIL post_apply_pc got=%h exp=%h", pc_val, e); end
    if (kill_fetch !== 1'b0) begin failures++; $display("FAIL kill_pulse got=%b exp=0", kill_fetch); end
  endtask

  task test_misalign;
    jalr_en = 1; rs1_val = 32'h1003; imm_val = 0; exp_q.push_back(32'h128);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL mis_pc got=%h exp=%h", pc_val, e); end
    if (misalign !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", misalign); end
    if (misalign_addr !== 32'h1002) begin failures++; $display("FAIL mis_addr got=%h exp=00001002", misalign_addr); end
    jalr_en = 0; rs1_val = 0; exp_q.push_back(32'h12C);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL mis_next_pc got=%h exp=%h", pc_val, e); end
    if (misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", misalign); end
    if (misalign_addr !== 32'h1002) begin failures++; $display("FAIL mis_hold got=%h exp=00001002", misalign_addr); end
  endtask

  task test_trap;
    fetch_ready = 0; jal_en = 1; imm_val = 32'h40; exp_q.push_back(32'h12C);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e || redir_pend !== 1'b1) begin failures++; $display("FAIL trap_setup got=%h/%b exp=%h/1", pc_val, redir_pend, e); end
    jal_en = 0; imm_val = 0; trap_en = 1; trap_vec = 32'h80; exp_q.push_back(32'h80);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL trap_pc got=%h exp=%h", pc_val, e); end
    if (redir_pend !== 1'b0) begin failures++; $display("FAIL trap_pend got=%b exp=0", redir_pend); end
    if (kill_fetch !== 1'b1) begin failures++; $display("FAIL trap_kill got=%b exp=1", kill_fetch); end
    trap_en = 0; trap_vec = 0; fetch_ready = 1; exp_q.push_back(32'h84);
    step; e = exp_q.pop_front(); checks += 2;
    if (pc_val !== e) begin failures++; $display("FAIL trap_drop got=%h exp=%h", pc_val, e); end
    if (kill_fetch !== 1'b0) begin failures++; $display("FAIL trap_kill_pulse got=%b exp=0", kill_fetch); end
  endtask

  task test_halt;
    fetch_ready = 0; jal_en = 1; imm_val = 32'h10; exp_q.push_back(32'h84);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e || redir_pend !== 1'b1) begin failures++; $display("FAIL halt_setup got=%h/%b exp=%h/1", pc_val, redir_pend, e); end
    jal_en = 0; imm_val = 0; halt = 1; #1; checks++;
    if (fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_fv got=%b exp=0", fetch_valid); end
    exp_q.push_back(32'h94);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL halt_apply_pc got=%h exp=%h", pc_val, e); end
    if (redir_pend !== 1'b0) begin failures++; $display("FAIL halt_pend got=%b exp=0", redir_pend); end
    if (kill_fetch !== 1'b0) begin failures++; $display("FAIL halt_kill got=%b exp=0", kill_fetch); end
    fetch_ready = 1; exp_q.push_back(32'h94);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e) begin failures++; $display("FAIL halt_hold_pc got=%h exp=%h", pc_val, e); end
    halt = 0; exp_q.push_back(32'h98);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e) begin failures++; $display("FAIL unhalt_pc got=%h exp=%h", pc_val, e); end
  endtask

  task test_priority;
    jalr_en = 1; jal_en = 1; br_taken = 1; rs1_val = 32'h400; imm_val = 32'h8; exp_q.push_back(32'h408);
    step; e = exp_q.pop_front(); checks += 2;
    if (pc_val !== e) begin failures++; $display("FAIL prio_jalr got=%h exp=%h", pc_val, e); end
    if (kill_fetch !== 1'b1) begin failures++; $display("FAIL prio_kill got=%b exp=1", kill_fetch); end
    jalr_en = 0; imm_val = 32'h20; exp_q.push_back(32'h428);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e) begin failures++; $display("FAIL prio_jal got=%h exp=%h", pc_val, e); end
    jal_en = 0; imm_val = 32'hFFFF_FFF8; exp_q.push_back(32'h420);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e) begin failures++; $display("FAIL br_back got=%h exp=%h", pc_val, e); end
    idle;
  endtask

  task test_ras;
    clr = 1; step; clr = 0; step;
    for (int i = 1; i <= 5; i++) begin
      ras_push = 1; t = 32'(4 * i); ras_q.push_back(t);
      if (ras_q.size() > 4) void'(ras_q.pop_front());
      exp_q.push_back(t);
      step; e = exp_q.pop_front(); checks += 2;
      if (pc_val !== e) begin failures++; $display("FAIL ras_pc got=%h exp=%h", pc_val, e); end
      if (ras_top !== t || ras_empty !== 1'b0) begin failures++; $display("FAIL ras_push_top got=%h/%b exp=%h/0", ras_top, ras_empty, t); end
    end
    ras_push = 0; fetch_ready = 0; #1; checks++;
    if (link_addr !== 32'h18) begin failures++; $display("FAIL link_addr got=%h exp=00000018", link_addr); end
    for (int i = 0; i < 5; i++) begin
      t = (ras_q.size() != 0) ? ras_q[$] : 32'h0; checks++;
      if (ras_top !== t) begin failures++; $display("FAIL ras_pop_top got=%h exp=%h", ras_top, t); end
      ras_pop = 1; step;
      if (ras_q.size() != 0) void'(ras_q.pop_back());
    end
    ras_pop = 0; checks += 2;
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL ras_final_empty got=%b exp=1", ras_empty); end
    if (ras_top !== 32'h0) begin failures++; $display("FAIL ras_final_top got=%h exp=0", ras_top); end
    ras_push = 1; ras_pop = 1; step; ras_push = 1; ras_pop = 1; t = link_addr;
    step; ras_push = 0; ras_pop = 0; checks++;
    if (ras_top !== t || ras_empty !== 1'b0) begin failures++; $display("FAIL ras_replace got=%h/%b exp=%h/0", ras_top, ras_empty, t); end
  endtask

  task test_clr;
    jal_en = 1; imm_val = 32'h100; step; jal_en = 0; imm_val = 0; checks++;
    if (redir_pend !== 1'b1) begin failures++; $display("FAIL clr_setup got=%b exp=1", redir_pend); end
    clr = 1; exp_q.push_back(32'h0);
    step; e = exp_q.pop_front(); checks += 3;
    if (pc_val !== e) begin failures++; $display("FAIL clr_pc got=%h exp=%h", pc_val, e); end
    if (redir_pend !== 1'b0) begin failures++; $display("FAIL clr_pend got=%b exp=0", redir_pend); end
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL clr_ras got=%b exp=1", ras_empty); end
    clr = 0; fetch_ready = 1; step; exp_q.push_back(32'h4);
    step; e = exp_q.pop_front(); checks++;
    if (pc_val !== e) begin failures++; $display("FAIL clr_resume got=%h exp=%h", pc_val, e); end
  endtask

  task test_wrap;
    idle; fetch_ready = 1; clr2 = 1; exp_q.push_back(32'hFFFF_FFF8);
    step; e = exp_q.pop_front(); checks += 2;
    if (pc2 !== e) begin failures++; $display("FAIL wrap_reset_pc got=%h exp=%h", pc2, e); end
    if (fv2 !== 1'b0) begin failures++; $display("FAIL wrap_reset_fv got=%b exp=0", fv2); end
    clr2 = 0;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) begin
      step; e = exp_q.pop_front(); checks++;
      if (pc2 !== e) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc2, e); end
    end
    clr2 = 1; exp_q.push_back(32'hFFFF_FFF8);
    step; e = exp_q.pop_front(); checks += 2;
    if (pc2 !== e) begin failures++; $display("FAIL wrap_clr_pc got=%h exp=%h", pc2, e); end
    if (fv2 !== 1'b0) begin failures++; $display("FAIL wrap_clr_fv got=%b exp=0", fv2); end
  endtask

  initial begin
    idle; clr = 1; clr2 = 1; fetch_ready = 0;
    step; step;
    test_reset;
    test_redirect;
    test_misalign;
    test_trap;
    test_halt;
    test_priority;
    test_ras;
    test_clr;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
